// File: rtl/quad_pkg.sv
// Shared phase constants, step-kind encoding and the phase-transition decode
// used by the quadrature step decoder.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_REV  = 2'd2,
    STEP_ERR  = 2'd3
  } step_kind_e;

  typedef enum logic [1:0] {
    PRIME_SYNC1 = 2'd0,
    PRIME_SYNC2 = 2'd1,
    PRIME_LOAD  = 2'd2,
    PRIME_RUN   = 2'd3
  } prime_state_e;

  // Forward order is 00->01->11->10->00; reverse is the exact inverse.
  function automatic step_kind_e decode_step(input logic [1:0] prv,
                                             input logic [1:0] cur);
    step_kind_e kind;
    case ({prv, cur})
      {PH_00, PH_01}, {PH_01, PH_11},
      {PH_11, PH_10}, {PH_10, PH_00}: kind = STEP_FWD;
      {PH_00, PH_10}, {PH_10, PH_11},
      {PH_11, PH_01}, {PH_01, PH_00}: kind = STEP_REV;
      {PH_00, PH_11}, {PH_11, PH_00},
      {PH_01, PH_10}, {PH_10, PH_01}: kind = STEP_ERR;
      default:                        kind = STEP_NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/quad_sync.sv
// Per-bit two-flop synchronizer for asynchronous phase pins.
module quad_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature step decoder: synchronizes A/B, decodes Gray transitions and
// accumulates a wrap-around signed position with step/dir/err flags.
//
// state       | meaning
// PRIME_SYNC1 | first cycle after reset, synchronizer stage 1 filling
// PRIME_SYNC2 | synchronizer stage 2 filling, cur not yet valid
// PRIME_LOAD  | cur valid, prv captures it; no decode yet
// PRIME_RUN   | primed, every prv->cur transition is decoded
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             clr,
  output logic [WIDTH-1:0] pos,
  output logic             step,
  output logic             dir,
  output logic             err
);

  localparam logic [WIDTH-1:0] POS_ONE = WIDTH'(1);

  logic [1:0]   cur;
  logic [1:0]   prv;
  step_kind_e   kind;
  prime_state_e prime_st;

  quad_sync #(.WIDTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({a_in, b_in}),
    .q   (cur)
  );

  assign kind = decode_step(prv, cur);

  // Priming waits for the synchronizer to hold real pin levels so the
  // level present at reset release is never taken for a transition.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prv      <= PH_00;
      prime_st <= PRIME_SYNC1;
      pos      <= '0;
      step     <= 1'b0;
      dir      <= 1'b0;
      err      <= 1'b0;
    end else begin
      prv  <= cur;
      step <= 1'b0;

      case (prime_st)
        PRIME_SYNC1: prime_st <= PRIME_SYNC2;
        PRIME_SYNC2: prime_st <= PRIME_LOAD;
        PRIME_LOAD:  prime_st <= PRIME_RUN;
        default:     prime_st <= PRIME_RUN;
      endcase

      if (clr) begin
        pos <= '0;
        err <= 1'b0;
      end else if (prime_st == PRIME_RUN) begin
        case (kind)
          STEP_FWD: begin
            pos  <= pos + POS_ONE;
            dir  <= 1'b0;
            step <= 1'b1;
          end
          STEP_REV: begin
            pos  <= pos - POS_ONE;
            dir  <= 1'b1;
            step <= 1'b1;
          end
          STEP_ERR: err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder with a step-event scoreboard.
module tb_quad_decoder;

  localparam int K_NONE = 0;
  localparam int K_FWD  = 1;
  localparam int K_REV  = 2;
  localparam int K_ERR  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_in = 1'b1;
  logic        b_in = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] pos;
  logic        step;
  logic        dir;
  logic        err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] pos;
    logic        dir;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got;

  logic [15:0] m_pos = 16'd0;
  logic        m_dir = 1'b0;

  quad_decoder #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .a_in (a_in),
    .b_in (b_in),
    .clr  (clr),
    .pos  (pos),
    .step (step),
    .dir  (dir),
    .err  (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Step pulses are matched against the scoreboard in order, value and cycle.
  always @(negedge clk) begin
    if (step === 1'b1) begin
      vectors++;
      assert (sb.size() > 0) else begin
        miscompares++;
        $error("FAIL unexpected_step: step=1 at cycle %0d, required no step", cyc);
      end
      if (sb.size() > 0) begin
        got = sb.pop_front();
        vectors++;
        assert (pos === got.pos) else begin
          miscompares++;
          $error("FAIL step_pos: got %0h required %0h", pos, got.pos);
        end
        vectors++;
        assert (dir === got.dir) else begin
          miscompares++;
          $error("FAIL step_dir: got %0b required %0b", dir, got.dir);
        end
        vectors++;
        assert (cyc === got.cyc) else begin
          miscompares++;
          $error("FAIL step_cycle: got %0d required %0d", cyc, got.cyc);
        end
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      got = sb.pop_front();
      vectors++;
      assert (step === 1'b1) else begin
        miscompares++;
        $error("FAIL missing_step: step=%0b at cycle %0d, required 1 at cycle %0d",
               step, cyc, got.cyc);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: got %0h required %0h", tag, obs, expv);
    end
  endtask

  task automatic move(input logic [1:0] ph, input int kind);
    exp_t e;
    @(negedge clk);
    {a_in, b_in} = ph;
    if (kind == K_FWD || kind == K_REV) begin
      m_pos = (kind == K_FWD) ? m_pos + 16'd1 : m_pos - 16'd1;
      m_dir = (kind == K_REV);
      e.pos = m_pos;
      e.dir = m_dir;
      e.cyc = cyc + 3;
      sb.push_back(e);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic clr_pulse();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_pos = 16'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pos"}, 32'(pos), 32'h0);
    chk({tag, "_step"}, 32'(step), 32'h0);
    chk({tag, "_dir"}, 32'(dir), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    // Reset held with both phases high; release must not produce a step.
    repeat (3) @(negedge clk);
    check_reset_values("rst1");
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("rel_pos", 32'(pos), 32'h0);
    chk("rel_err", 32'(err), 32'h0);

    move(2'b10, K_FWD);
    move(2'b00, K_FWD);
    chk("walk_pos", 32'(pos), 32'(m_pos));
    clr_pulse();
    chk("clr0_pos", 32'(pos), 32'h0);

    // Eight forward steps.
    for (int i = 0; i < 2; i++) begin
      move(2'b01, K_FWD);
      move(2'b11, K_FWD);
      move(2'b10, K_FWD);
      move(2'b00, K_FWD);
    end
    chk("fwd8_pos", 32'(pos), 32'd8);
    chk("fwd8_dir", 32'(dir), 32'h0);

    // Reverse through zero.
    clr_pulse();
    move(2'b10, K_REV);
    chk("rev1_pos", 32'(pos), 32'hFFFF);
    chk("rev1_dir", 32'(dir), 32'h1);
    move(2'b11, K_REV);
    move(2'b01, K_REV);
    move(2'b00, K_REV);
    chk("rev4_pos", 32'(pos), 32'hFFFC);

    // Illegal transition, counting continues, clr clears.
    move(2'b11, K_ERR);
    chk("ill_err", 32'(err), 32'h1);
    chk("ill_pos", 32'(pos), 32'hFFFC);
    move(2'b10, K_FWD);
    chk("ill_fwd_pos", 32'(pos), 32'hFFFD);
    chk("ill_fwd_err", 32'(err), 32'h1);
    clr_pulse();
    chk("ill_clr_pos", 32'(pos), 32'h0);
    chk("ill_clr_err", 32'(err), 32'h0);

    // clr coincident with a decoded forward step drops it.
    move(2'b11, K_REV);
    move(2'b01, K_REV);
    chk("pre_clr_pos", 32'(pos), 32'hFFFE);
    chk("pre_clr_dir", 32'(dir), 32'h1);
    @(negedge clk);
    {a_in, b_in} = 2'b11;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_pos = 16'd0;
    repeat (3) @(negedge clk);
    chk("coin_pos", 32'(pos), 32'h0);
    chk("coin_dir", 32'(dir), 32'h1);
    chk("coin_step", 32'(step), 32'h0);
    move(2'b10, K_FWD);
    chk("post_coin_pos", 32'(pos), 32'h1);
    chk("post_coin_dir", 32'(dir), 32'h0);

    // Reset mid-operation at pos=5 with phases at 11.
    move(2'b00, K_FWD);
    move(2'b01, K_FWD);
    clr_pulse();
    move(2'b11, K_FWD);
    move(2'b10, K_FWD);
    move(2'b00, K_FWD);
    move(2'b01, K_FWD);
    move(2'b11, K_FWD);
    chk("mid_pos", 32'(pos), 32'd5);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("rst2");
    rst = 1'b1;
    m_pos = 16'd0;
    m_dir = 1'b0;
    repeat (8) @(negedge clk);
    chk("rel2_pos", 32'(pos), 32'h0);
    chk("rel2_err", 32'(err), 32'h0);
    move(2'b10, K_FWD);
    chk("rel2_fwd_pos", 32'(pos), 32'h1);
    chk("rel2_fwd_dir", 32'(dir), 32'h0);

    repeat (4) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
